// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive-path width and depth defaults
package uart_pkg;
   localparam int UART_DBIT        = 8;
   localparam int UART_FIFO_ADDR_W = 4;
   localparam int UART_OVF_CNT_W   = 8;
endpackage

// File: rtl/uart_fifo_regfile.sv
// uart_fifo_regfile: unreset storage array, synchronous write, asynchronous read
module uart_fifo_regfile import uart_pkg::*; #(
   parameter int DBIT   = UART_DBIT,
   parameter int ADDR_W = UART_FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DBIT-1:0]   wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DBIT-1:0]   rd_data
);
   logic [DBIT-1:0] mem [2**ADDR_W];
   always_ff @(posedge clk)
      if (wr_en) mem[wr_addr] <= wr_data;
   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive FIFO with sticky overflow; UART_RX_FIFO_OVF_CNT_EN adds a saturating drop counter
module uart_rx_fifo import uart_pkg::*; #(
   parameter int DBIT   = UART_DBIT,
   parameter int ADDR_W = UART_FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_done_tick,
   input  logic [DBIT-1:0]   din,
   input  logic              rd,
   input  logic              ovf_clr,
   output logic [DBIT-1:0]   rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow
`ifdef UART_RX_FIFO_OVF_CNT_EN
  ,output logic [UART_OVF_CNT_W-1:0] ovf_cnt
`endif
);
   localparam logic [ADDR_W:0] PTR_ONE = 1;
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
   logic            wr_en, rd_en, drop;
   logic [DBIT-1:0] mem_data;
   always_comb begin
      wr_en      = rx_done_tick && (!full || rd);
      rd_en      = rd && !empty;
      drop       = rx_done_tick && full && !rd;
      wr_ptr_d   = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      overflow_d = drop ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end
`ifdef UART_RX_FIFO_OVF_CNT_EN
   localparam logic [UART_OVF_CNT_W-1:0] CNT_ONE = 1;
   logic [UART_OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
   always_comb
      ovf_cnt_d = ovf_clr ? (drop ? CNT_ONE : '0)
                : (drop && ovf_cnt_q != '1) ? ovf_cnt_q + CNT_ONE : ovf_cnt_q;
   always_ff @(posedge clk)
      ovf_cnt_q <= reset ? '0 : ovf_cnt_d;
   assign ovf_cnt = ovf_cnt_q;
`endif
   uart_fifo_regfile #(.DBIT(DBIT), .ADDR_W(ADDR_W)) u_regfile (
      .clk    (clk),
      .wr_en  (wr_en && !reset),
      .wr_addr(wr_ptr_q[ADDR_W-1:0]),
      .wr_data(din),
      .rd_addr(rd_ptr_q[ADDR_W-1:0]),
      .rd_data(mem_data)
   );
   // status derives only from registered pointers; rd_data reads 0 while empty
   assign empty    = wr_ptr_q == rd_ptr_q;
   assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign count    = wr_ptr_q - rd_ptr_q;
   assign rd_data  = empty ? '0 : mem_data;
   assign overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard-driven bench for uart_rx_fifo at depth 4
module tb_uart_rx_fifo;
   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;
   logic       clk = 0, reset = 0, rx_done_tick = 0, rd = 0, ovf_clr = 0;
   logic [7:0] din = '0, rd_data;
   logic       empty, full, overflow;
   logic [ADDR_W:0] count;
`ifdef UART_RX_FIFO_OVF_CNT_EN
   logic [7:0] ovf_cnt;
   int         cnt_m = 0;
`endif
   logic [7:0] q[$];
   logic       ovf_m = 0;
   int         n_chk = 0, n_fail = 0;

   uart_rx_fifo #(.DBIT(8), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din), .rd(rd),
      .ovf_clr(ovf_clr), .rd_data(rd_data), .empty(empty), .full(full),
      .count(count), .overflow(overflow)
`ifdef UART_RX_FIFO_OVF_CNT_EN
     ,.ovf_cnt(ovf_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step(input logic t, input logic [7:0] d, input logic r, input logic c);
      int  n;
      bit  drop;
      rx_done_tick = t; din = d; rd = r; ovf_clr = c;
      @(posedge clk);
      n    = q.size();
      drop = t && n == DEPTH && !r;
      if (r && n > 0) void'(q.pop_front());
      if (t && (n < DEPTH || r)) q.push_back(d);
      ovf_m = drop ? 1'b1 : c ? 1'b0 : ovf_m;
`ifdef UART_RX_FIFO_OVF_CNT_EN
      cnt_m = c ? (drop ? 1 : 0) : (drop && cnt_m < 255) ? cnt_m + 1 : cnt_m;
`endif
      #1;
      rx_done_tick = 0; rd = 0; ovf_clr = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      @(posedge clk);
      q.delete(); ovf_m = 0;
`ifdef UART_RX_FIFO_OVF_CNT_EN
      cnt_m = 0;
`endif
      #1 reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
      n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
      n_chk++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
      n_chk++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
   endtask

   task automatic test_single();
      step(1, 8'hA5, 0, 0);
      n_chk++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b want 0", empty); end
      n_chk++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
      n_chk++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", rd_data); end
      step(0, 8'h00, 1, 0);
      n_chk++; if (empty !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL single_pop empty=%b count=%0d want 1/0", empty, count); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
      n_chk++; if (full !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL ovf_fill full=%b count=%0d want 1/4", full, count); end
      step(1, 8'h05, 0, 0);
      n_chk++; if (overflow !== 1'b1 || overflow !== ovf_m) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
      n_chk++; if (int'(count) !== q.size()) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", count, q.size()); end
`ifdef UART_RX_FIFO_OVF_CNT_EN
      n_chk++; if (int'(ovf_cnt) !== cnt_m) begin n_fail++; $display("FAIL ovf_cnt got %0d want %0d", ovf_cnt, cnt_m); end
`endif
      for (int i = 1; i <= 4; i++) begin
         n_chk++; if (rd_data !== q[0] || rd_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_pop%0d got %h want %h", i, rd_data, q[0]); end
         step(0, 8'h00, 1, 0);
      end
      n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained empty=%b want 1", empty); end
   endtask

   task automatic test_ovf_clr();
      step(0, 8'h00, 0, 1);
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got %b want 0", overflow); end
`ifdef UART_RX_FIFO_OVF_CNT_EN
      n_chk++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_ovf_cnt got %0d want 0", ovf_cnt); end
`endif
      for (int i = 0; i < 4; i++) step(1, 8'h40 + 8'(i), 0, 0);
      step(1, 8'h99, 0, 1);
      n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL set_wins got %b want 1", overflow); end
`ifdef UART_RX_FIFO_OVF_CNT_EN
      n_chk++; if (ovf_cnt !== 8'd1 || int'(ovf_cnt) !== cnt_m) begin n_fail++; $display("FAIL set_wins_cnt got %0d want 1", ovf_cnt); end
`endif
      step(0, 8'h00, 0, 1);
      while (q.size() > 0) begin
         n_chk++; if (rd_data !== q[0]) begin n_fail++; $display("FAIL clr_pop got %h want %h", rd_data, q[0]); end
         step(0, 8'h00, 1, 0);
      end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 4; i++) step(1, 8'h21 + 8'(i), 0, 0);
      step(1, 8'h77, 1, 0);
      n_chk++; if (count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL full_rw count=%0d full=%b want 4/1", count, full); end
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_rw_ovf got %b want 0", overflow); end
      for (int i = 0; i < 4; i++) begin
         n_chk++; if (rd_data !== q[0]) begin n_fail++; $display("FAIL full_rw_pop%0d got %h want %h", i, rd_data, q[0]); end
         if (i == 3) begin
            n_chk++; if (rd_data !== 8'h77) begin n_fail++; $display("FAIL full_rw_last got %h want 77", rd_data); end
         end
         step(0, 8'h00, 1, 0);
      end
   endtask

   task automatic test_empty_rw();
      step(1, 8'h3C, 1, 0);
      n_chk++; if (count !== 3'd1 || rd_data !== 8'h3C) begin n_fail++; $display("FAIL empty_rw count=%0d data=%h want 1/3c", count, rd_data); end
      step(0, 8'h00, 1, 0);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         step(1, 8'h10 + 8'(i), 0, 0);
         n_chk++; if (empty !== 1'b0 || full !== 1'b0 || rd_data !== q[0]) begin n_fail++; $display("FAIL wrap_wr%0d empty=%b full=%b data=%h want 0/0/%h", i, empty, full, rd_data, q[0]); end
         n_chk++; if (rd_data !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL wrap_val%0d got %h want %h", i, rd_data, 8'h10 + 8'(i)); end
         step(0, 8'h00, 1, 0);
         n_chk++; if (empty !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL wrap_rd%0d empty=%b count=%0d want 1/0", i, empty, count); end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         step(1, 8'hB0 + 8'(i), (i % 2) == 1, 0);
         n_chk++; if (int'(count) !== q.size() || full !== (q.size() == DEPTH) || overflow !== ovf_m) begin
            n_fail++; $display("FAIL b2b%0d count=%0d full=%b ovf=%b want %0d/%b/%b", i, count, full, overflow, q.size(), q.size() == DEPTH, ovf_m);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0, 0);
      rx_done_tick = 1; din = 8'hEE; rd = 1;
      do_reset();
      rx_done_tick = 0; rd = 0;
      n_chk++; if (empty !== 1'b1 || count !== 3'd0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset empty=%b count=%0d data=%h want 1/0/00", empty, count, rd_data); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_ovf_clr();
      test_full_rw();
      test_empty_rw();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
